// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between the fetch (inst) and load/store (data) requesters.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN swaps fixed data priority for alternating priority.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; grant combinationally when a request is present
// ISSUE  | SRAM access driven (sram_en=1) from the latched request
// WAIT   | read latency countdown; capture sram_rdata when counter hits 0
// RESP   | one-cycle data_ok pulse to the owner
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..3");
    end

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;   // 1 = data requester owns the transaction
    logic [1:0]        cnt_q, cnt_d;
    logic              sram_en_q, sram_en_d;
    logic [STRB_W-1:0] sram_we_q, sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic data_wins;
    logic idle_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;  // 1 = data was granted last

    assign data_wins    = data_req && (!inst_req || !last_owner_q);
    assign last_owner_d = (inst_addr_ok || data_addr_ok) ? data_addr_ok : last_owner_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign data_wins = data_req;
`endif

    // Grants are combinational, so gate with resetn to keep them low while reset is held.
    assign idle_ready   = (state_q == S_IDLE) && resetn;
    assign data_addr_ok = idle_ready && data_wins;
    assign inst_addr_ok = idle_ready && inst_req && !data_wins;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        sram_en_d    = 1'b0;
        sram_we_d    = '0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (data_addr_ok) begin
                    state_d      = S_ISSUE;
                    owner_d      = 1'b1;
                    sram_en_d    = 1'b1;
                    sram_we_d    = data_wstrb;
                    sram_addr_d  = data_addr;
                    sram_wdata_d = data_wdata;
                end else if (inst_addr_ok) begin
                    state_d      = S_ISSUE;
                    owner_d      = 1'b0;
                    sram_en_d    = 1'b1;
                    sram_addr_d  = inst_addr;
                    sram_wdata_d = '0;
                end
            end
            S_ISSUE: begin
                if (sram_we_q != '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (owner_q) begin
                        data_rdata_d = sram_rdata;
                    end else begin
                        inst_rdata_d = sram_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            cnt_q        <= 2'd0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign sram_en      = sram_en_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign inst_data_ok = (state_q == S_RESP) && !owner_q;
    assign data_data_ok = (state_q == S_RESP) && owner_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3,
// each attached to its own behavioural SRAM; expectations come from a word-level memory model.
module tb_mem_port_arbiter;
    logic        clk;
    logic        resetn;
    logic        inst_req     [2];
    logic [31:0] inst_addr    [2];
    logic        inst_addr_ok [2];
    logic        inst_data_ok [2];
    logic [31:0] inst_rdata   [2];
    logic        data_req     [2];
    logic [31:0] data_addr    [2];
    logic [3:0]  data_wstrb   [2];
    logic [31:0] data_wdata   [2];
    logic        data_addr_ok [2];
    logic        data_data_ok [2];
    logic [31:0] data_rdata   [2];
    logic        sram_en      [2];
    logic [3:0]  sram_we      [2];
    logic [31:0] sram_addr    [2];
    logic [31:0] sram_wdata   [2];
    logic [31:0] sram_rdata   [2];
    logic        busy         [2];

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [2][64];
    logic [31:0] exp_ird [2];
    logic [31:0] exp_drd [2];

    bit          t_granted;
    int          t_lat, t_en_first, t_en_cnt;
    logic [31:0] t_rd, t_addr1, t_wdata1;
    logic [3:0]  t_we1;
    logic        t_busy_after;

    function automatic logic [31:0] init_word(int g, int i);
        return (32'(i + 1) * 32'h9e3779b1) ^ (g != 0 ? 32'h5a5a5a5a : 32'h0);
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .resetn(resetn),
            .inst_req(inst_req[g]), .inst_addr(inst_addr[g]),
            .inst_addr_ok(inst_addr_ok[g]), .inst_data_ok(inst_data_ok[g]), .inst_rdata(inst_rdata[g]),
            .data_req(data_req[g]), .data_addr(data_addr[g]), .data_wstrb(data_wstrb[g]),
            .data_wdata(data_wdata[g]), .data_addr_ok(data_addr_ok[g]),
            .data_data_ok(data_data_ok[g]), .data_rdata(data_rdata[g]),
            .sram_en(sram_en[g]), .sram_we(sram_we[g]), .sram_addr(sram_addr[g]),
            .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g]), .busy(busy[g])
        );

        logic [31:0] smem [64];
        logic [31:0] pipe [3];
        bit          init_done = 1'b0;

        always @(posedge clk) begin
            if (!init_done) begin
                for (int i = 0; i < 64; i++) smem[i] <= init_word(g, i);
                init_done <= 1'b1;
            end else if (sram_en[g] && sram_we[g] != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[g][b]) smem[sram_addr[g][7:2]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
            end
            pipe[0] <= (sram_en[g] && sram_we[g] == 4'h0) ? smem[sram_addr[g][7:2]] : 32'hbad0bad0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        assign sram_rdata[g] = pipe[g == 0 ? 0 : 2];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference model: applies one accepted transaction at word level.
    task automatic model_apply(input int k, input bit d, input logic [31:0] a, input logic [3:0] ws,
                               input logic [31:0] wd, output int exp_lat, output logic [31:0] exp_rd);
        int idx;
        idx = int'(a[7:2]);
        if (d && ws != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_mem[k][idx][8*b +: 8] = wd[8*b +: 8];
            exp_lat = 2;
            exp_rd  = exp_drd[k];
        end else begin
            exp_rd  = ref_mem[k][idx];
            exp_lat = 2 + lat_of(k);
            if (d) exp_drd[k] = exp_rd;
            else   exp_ird[k] = exp_rd;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_ird[k] = '0;
            exp_drd[k] = '0;
        end
    endtask

    // Drives one request, releases it after the grant cycle, and records what the DUT did.
    task automatic run_txn(input int k, input bit d, input logic [31:0] a, input logic [3:0] ws,
                           input logic [31:0] wd);
        t_granted = 1'b0; t_lat = -1; t_rd = 'x; t_en_first = -1; t_en_cnt = 0;
        t_we1 = '0; t_addr1 = '0; t_wdata1 = '0;
        @(posedge clk); #1;
        if (d) begin
            data_req[k] = 1'b1; data_addr[k] = a; data_wstrb[k] = ws; data_wdata[k] = wd;
        end else begin
            inst_req[k] = 1'b1; inst_addr[k] = a;
        end
        @(negedge clk);
        t_granted = d ? data_addr_ok[k] : inst_addr_ok[k];
        @(posedge clk); #1;
        inst_req[k] = 1'b0; data_req[k] = 1'b0;
        inst_addr[k] = $urandom; data_addr[k] = $urandom;
        data_wdata[k] = $urandom; data_wstrb[k] = 4'($urandom);
        if (t_granted) begin
            for (int c = 1; c <= 12 && t_lat < 0; c++) begin
                @(negedge clk);
                if (sram_en[k]) begin
                    t_en_cnt++;
                    if (t_en_first < 0) begin
                        t_en_first = c; t_we1 = sram_we[k]; t_addr1 = sram_addr[k]; t_wdata1 = sram_wdata[k];
                    end
                end
                if (d ? data_data_ok[k] : inst_data_ok[k]) begin
                    t_lat = c;
                    t_rd  = d ? data_rdata[k] : inst_rdata[k];
                end
            end
        end
        @(negedge clk);
        t_busy_after = busy[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            inst_req[k] = 1'b1; data_req[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k], data_data_ok[k], busy[k], sram_en[k]} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl[%0d]: got ok/busy/en=%b want 000000", k,
                         {inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k], data_data_ok[k], busy[k], sram_en[k]});
            end
            vectors++;
            if ({sram_we[k], sram_addr[k], sram_wdata[k]} !== 68'h0) begin
                miscompares++;
                $display("FAIL reset_sram[%0d]: got we=%h addr=%h wdata=%h want 0", k, sram_we[k], sram_addr[k], sram_wdata[k]);
            end
            vectors++;
            if ({inst_rdata[k], data_rdata[k]} !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_rdata[%0d]: got %h/%h want 0", k, inst_rdata[k], data_rdata[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            inst_req[k] = 1'b0; data_req[k] = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_inst_read();
        int el; logic [31:0] er;
        model_apply(0, 1'b1, 32'h1c000000, 4'hf, 32'h02800421, el, er);
        run_txn(0, 1'b1, 32'h1c000000, 4'hf, 32'h02800421);
        vectors++;
        if (!t_granted || t_lat !== 2) begin
            miscompares++; $display("FAIL inst_preload: got grant=%0d lat=%0d want 1/2", t_granted, t_lat);
        end
        model_apply(0, 1'b0, 32'h1c000000, 4'h0, 32'h0, el, er);
        run_txn(0, 1'b0, 32'h1c000000, 4'h0, 32'h0);
        vectors++;
        if (!t_granted) begin miscompares++; $display("FAIL inst_grant: got 0 want 1"); end
        vectors++;
        if (t_lat !== 3) begin miscompares++; $display("FAIL inst_latency: got %0d want 3", t_lat); end
        vectors++;
        if (t_rd !== 32'h02800421) begin miscompares++; $display("FAIL inst_rdata: got %h want 02800421", t_rd); end
        vectors++;
        if (t_en_first !== 1 || t_en_cnt !== 1 || t_addr1 !== 32'h1c000000 || t_we1 !== 4'h0) begin
            miscompares++;
            $display("FAIL inst_sram: got en_at=%0d en_cnt=%0d addr=%h we=%h want 1/1/1c000000/0", t_en_first, t_en_cnt, t_addr1, t_we1);
        end
        vectors++;
        if (t_busy_after !== 1'b0) begin miscompares++; $display("FAIL inst_busy_after: got %b want 0", t_busy_after); end
    endtask

    task automatic test_write_readback();
        int el; logic [31:0] er;
        model_apply(0, 1'b1, 32'h10, 4'hf, 32'hdeadbeef, el, er);
        run_txn(0, 1'b1, 32'h10, 4'hf, 32'hdeadbeef);
        vectors++;
        if (!t_granted || t_lat !== 2) begin
            miscompares++; $display("FAIL write_latency: got grant=%0d lat=%0d want 1/2", t_granted, t_lat);
        end
        vectors++;
        if (t_en_first !== 1 || t_we1 !== 4'hf || t_wdata1 !== 32'hdeadbeef) begin
            miscompares++; $display("FAIL write_sram: got en_at=%0d we=%h wdata=%h want 1/f/deadbeef", t_en_first, t_we1, t_wdata1);
        end
        model_apply(0, 1'b1, 32'h10, 4'h0, 32'h0, el, er);
        run_txn(0, 1'b1, 32'h10, 4'h0, 32'h0);
        vectors++;
        if (t_lat !== 3 || t_rd !== 32'hdeadbeef) begin
            miscompares++; $display("FAIL write_readback: got lat=%0d data=%h want 3/deadbeef", t_lat, t_rd);
        end
    endtask

    task automatic test_partial_store();
        int el; logic [31:0] er;
        model_apply(0, 1'b1, 32'h20, 4'hf, 32'h11223344, el, er);
        run_txn(0, 1'b1, 32'h20, 4'hf, 32'h11223344);
        model_apply(0, 1'b1, 32'h20, 4'b0010, 32'h0000aa00, el, er);
        run_txn(0, 1'b1, 32'h20, 4'b0010, 32'h0000aa00);
        vectors++;
        if (t_we1 !== 4'b0010 || t_lat !== 2) begin
            miscompares++; $display("FAIL partial_we: got we=%b lat=%0d want 0010/2", t_we1, t_lat);
        end
        model_apply(0, 1'b1, 32'h20, 4'h0, 32'h0, el, er);
        run_txn(0, 1'b1, 32'h20, 4'h0, 32'h0);
        vectors++;
        if (t_rd !== 32'h1122aa44) begin miscompares++; $display("FAIL partial_readback: got %h want 1122aa44", t_rd); end
    endtask

    task automatic test_rd_lat3();
        int el; logic [31:0] er;
        model_apply(1, 1'b1, 32'h30, 4'h0, 32'h0, el, er);
        run_txn(1, 1'b1, 32'h30, 4'h0, 32'h0);
        vectors++;
        if (!t_granted || t_lat !== 5) begin
            miscompares++; $display("FAIL lat3_latency: got grant=%0d lat=%0d want 1/5", t_granted, t_lat);
        end
        vectors++;
        if (t_en_first !== 1 || t_en_cnt !== 1) begin
            miscompares++; $display("FAIL lat3_sram_en: got at=%0d cnt=%0d want 1/1", t_en_first, t_en_cnt);
        end
        vectors++;
        if (t_rd !== er) begin miscompares++; $display("FAIL lat3_rdata: got %h want %h", t_rd, er); end
    endtask

    task automatic test_random();
        int k, idx, el; bit d; logic [31:0] a, wd, er; logic [3:0] ws; bit wr;
        for (int n = 0; n < 40; n++) begin
            k   = $urandom_range(0, 1);
            d   = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63);
            a   = ($urandom & 32'hffffff00) | 32'(idx << 2);
            ws  = (d && $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            wd  = $urandom;
            wr  = d && (ws != 4'h0);
            model_apply(k, d, a, ws, wd, el, er);
            run_txn(k, d, a, ws, wd);
            vectors++;
            if (!t_granted || t_lat !== el) begin
                miscompares++; $display("FAIL rand_latency n=%0d k=%0d: got grant=%0d lat=%0d want 1/%0d", n, k, t_granted, t_lat, el);
            end
            vectors++;
            if (t_en_first !== 1 || t_en_cnt !== 1 || t_addr1 !== a || t_we1 !== ws || (wr && t_wdata1 !== wd)) begin
                miscompares++;
                $display("FAIL rand_sram n=%0d: got en_at=%0d cnt=%0d addr=%h we=%h wdata=%h want 1/1/%h/%h/%h",
                         n, t_en_first, t_en_cnt, t_addr1, t_we1, t_wdata1, a, ws, wd);
            end
            if (!wr) begin
                vectors++;
                if (t_rd !== er) begin miscompares++; $display("FAIL rand_rdata n=%0d: got %h want %h", n, t_rd, er); end
            end
            vectors++;
            if (inst_rdata[k] !== exp_ird[k] || data_rdata[k] !== exp_drd[k]) begin
                miscompares++;
                $display("FAIL rand_hold n=%0d: got %h/%h want %h/%h", n, inst_rdata[k], data_rdata[k], exp_ird[k], exp_drd[k]);
            end
            vectors++;
            if (t_busy_after !== 1'b0) begin miscompares++; $display("FAIL rand_busy n=%0d: got 1 want 0", n); end
        end
    endtask

    task automatic test_contention();
        bit got [4]; bit expo [4]; bit last; bit both_seen; int ng, el; logic [31:0] er;
        do_reset();
        last = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            expo[i] = !last;
`else
            expo[i] = 1'b1;
`endif
            last = expo[i];
        end
        ng = 0; both_seen = 1'b0;
        @(posedge clk); #1;
        inst_req[0] = 1'b1; inst_addr[0] = 32'h40;
        data_req[0] = 1'b1; data_addr[0] = 32'h80; data_wstrb[0] = 4'h0; data_wdata[0] = 32'h0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (inst_addr_ok[0] && data_addr_ok[0]) both_seen = 1'b1;
            if (inst_addr_ok[0] || data_addr_ok[0]) begin
                got[ng] = data_addr_ok[0];
                ng++;
            end
        end
        @(posedge clk); #1;
        inst_req[0] = 1'b0; data_req[0] = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (ng !== 4 || both_seen) begin
            miscompares++; $display("FAIL contention_grants: got %0d grants both=%0d want 4/0", ng, both_seen);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i < ng && got[i] !== expo[i]) begin
                miscompares++; $display("FAIL contention_order[%0d]: got data=%0d want data=%0d", i, got[i], expo[i]);
            end
            model_apply(0, expo[i], expo[i] ? 32'h80 : 32'h40, 4'h0, 32'h0, el, er);
        end
        vectors++;
        if (inst_rdata[0] !== exp_ird[0] || data_rdata[0] !== exp_drd[0]) begin
            miscompares++;
            $display("FAIL contention_rdata: got %h/%h want %h/%h", inst_rdata[0], data_rdata[0], exp_ird[0], exp_drd[0]);
        end
    endtask

    task automatic test_reset_mid();
        int oks, el; logic [31:0] er; bit g;
        @(posedge clk); #1;
        data_req[1] = 1'b1; data_addr[1] = 32'h14; data_wstrb[1] = 4'h0;
        @(negedge clk);
        g = data_addr_ok[1];
        @(posedge clk); #1;
        data_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if (!g || {sram_en[1], sram_we[1], busy[1], data_data_ok[1]} !== 7'b0 ||
            {sram_addr[1], sram_wdata[1], data_rdata[1]} !== 96'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got grant=%0d en=%b we=%h busy=%b addr=%h want 1/0/0/0/0", g, sram_en[1], sram_we[1], busy[1], sram_addr[1]);
        end
        for (int k = 0; k < 2; k++) begin
            exp_ird[k] = '0; exp_drd[k] = '0;
        end
        oks = 0;
        repeat (2) begin @(negedge clk); if (data_data_ok[1]) oks++; end
        resetn = 1'b1;
        repeat (8) begin @(negedge clk); if (data_data_ok[1]) oks++; end
        vectors++;
        if (oks !== 0) begin miscompares++; $display("FAIL midreset_no_ok: got %0d pulses want 0", oks); end
        model_apply(1, 1'b0, 32'h1c00001c, 4'h0, 32'h0, el, er);
        run_txn(1, 1'b0, 32'h1c00001c, 4'h0, 32'h0);
        vectors++;
        if (!t_granted || t_lat !== el || t_rd !== er) begin
            miscompares++; $display("FAIL midreset_recover: got grant=%0d lat=%0d data=%h want 1/%0d/%h", t_granted, t_lat, t_rd, el, er);
        end
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            inst_req[k] = 1'b0; inst_addr[k] = '0;
            data_req[k] = 1'b0; data_addr[k] = '0; data_wstrb[k] = '0; data_wdata[k] = '0;
            exp_ird[k] = '0; exp_drd[k] = '0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(k, i);
        end
        test_reset();
        test_inst_read();
        test_write_readback();
        test_partial_store();
        test_rd_lat3();
        test_random();
        test_contention();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
